// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Width of a down-counter that must hold LAT-1; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

  // Address bits needed to index a DEPTH-word array.
  function automatic int ram_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM. The read port is registered and only updates on
// a read, so the last read word stays on rdata across later writes. Contents
// are never reset.
module ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write and registered read share the single port.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
    if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: latches one request,
// waits LAT cycles, performs the RAM access and pulses done.
//
// state  | meaning
// IDLE   | waiting; a request is taken when exactly one strobe is high
// ACCESS | counting down; access happens on the edge where cnt is 0
// DONE   | one-cycle completion, read data valid on MDatain
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 512,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] MDatain,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = cnt_width(LAT);
  localparam int RAM_AW = ram_aw(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;
  logic              err_q, err_d;
  // Set once an in-range read has loaded the RAM read register; masks the
  // uninitialised register after reset and forces zero after a bad read.
  logic              rd_valid_q, rd_valid_d;

  logic              in_range;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = (32'(addr_q) < 32'(DEPTH));

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    err_d      = 1'b0;
    rd_valid_d = rd_valid_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (read ^ write) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = write ? OP_WR : OP_RD;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end else if (read && write) begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (in_range) begin
            ram_en = 1'b1;
            ram_we = (op_q == OP_WR);
            if (op_q == OP_RD) begin
              rd_valid_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (op_q == OP_RD) begin
              rd_valid_d = 1'b0;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset on the access edge must not commit a write.
    if (clr) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // State register with synchronous reset; RAM contents are untouched.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= OP_RD;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  ram_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (addr_q[RAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign MDatain = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int NI = 4;
  localparam int LATS   [NI] = '{2, 1, 4, 3};
  localparam int DEPTHS [NI] = '{512, 512, 512, 256};

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rd    [NI];
  logic        wr    [NI];
  logic [8:0]  addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] mdat  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        err   [NI];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [int];
  logic [31:0] last_rd [NI];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .LAT(2)) u_l2 (
    .clk(clk), .clr(clr), .read(rd[0]), .write(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .MDatain(mdat[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .LAT(1)) u_l1 (
    .clk(clk), .clr(clr), .read(rd[1]), .write(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .MDatain(mdat[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));
  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .LAT(4)) u_l4 (
    .clk(clk), .clr(clr), .read(rd[2]), .write(wr[2]), .addr(addr[2]), .wdata(wdata[2]),
    .MDatain(mdat[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));
  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .LAT(3)) u_l3 (
    .clk(clk), .clr(clr), .read(rd[3]), .write(wr[3]), .addr(addr[3]), .wdata(wdata[3]),
    .MDatain(mdat[3]), .busy(busy[3]), .done(done[3]), .err(err[3]));

  typedef struct {
    int          inst;
    bit          is_wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key(input int k, input logic [8:0] a);
    return k * 1024 + int'(a);
  endfunction

  // One complete request with per-cycle protocol checks. Optional stress mode
  // disturbs addr/wdata and pulses read while the request is in flight.
  task automatic xact(input int k, input bit is_wr, input logic [8:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit stress);
    int  lat;
    bit  oor;
    lat = LATS[k];
    oor = (int'(a) >= DEPTHS[k]);
    @(negedge clk);
    rd[k] = !is_wr; wr[k] = is_wr; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        rd[k] = 1'b0; wr[k] = 1'b0;
        if (stress) begin
          rd[k] = 1'b1; addr[k] = a + 9'd1; wdata[k] = 32'h2222_2222;
        end
      end
      if (n == 2 && stress) rd[k] = 1'b0;
      chk($sformatf("busy i%0d n%0d", k, n), {31'b0, busy[k]}, 32'd1);
      chk($sformatf("done i%0d n%0d", k, n), {31'b0, done[k]}, {31'b0, n == lat + 1});
      chk($sformatf("err i%0d n%0d", k, n), {31'b0, err[k]}, {31'b0, (n == lat + 1) && oor});
      if (n == lat + 1) begin
        if (!is_wr) last_rd[k] = exp_rd;
        chk($sformatf("mdat_done i%0d a%h", k, a), mdat[k], last_rd[k]);
      end
    end
    rd[k] = 1'b0;
    if (is_wr && !oor) model[key(k, a)] = d;
    @(negedge clk);
    chk($sformatf("busy_after i%0d", k), {31'b0, busy[k]}, 32'd0);
    chk($sformatf("done_after i%0d", k), {31'b0, done[k]}, 32'd0);
    chk($sformatf("mdat_hold i%0d", k), mdat[k], last_rd[k]);
    addr[k] = '0; wdata[k] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   dpos[$];
    for (int k = 0; k < NI; k++) begin
      rd[k] = 0; wr[k] = 0; addr[k] = '0; wdata[k] = '0; last_rd[k] = '0;
    end

    vecs.push_back('{0, 1'b1, 9'h010, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{0, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1, 1'b1, 9'h020, 32'hA5A5_A5A5, 32'h0});
    vecs.push_back('{1, 1'b0, 9'h020, 32'h0, 32'hA5A5_A5A5});
    vecs.push_back('{2, 1'b1, 9'h030, 32'h0F0F_0F0F, 32'h0});
    vecs.push_back('{2, 1'b0, 9'h030, 32'h0, 32'h0F0F_0F0F});
    vecs.push_back('{3, 1'b1, 9'h000, 32'h1357_2468, 32'h0});
    vecs.push_back('{3, 1'b1, 9'h100, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{3, 1'b0, 9'h000, 32'h0, 32'h1357_2468});
    vecs.push_back('{3, 1'b0, 9'h1FF, 32'h0, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_busy i%0d", k), {31'b0, busy[k]}, 32'd0);
      chk($sformatf("rst_done i%0d", k), {31'b0, done[k]}, 32'd0);
      chk($sformatf("rst_err i%0d", k), {31'b0, err[k]}, 32'd0);
      chk($sformatf("rst_mdat i%0d", k), mdat[k], 32'd0);
    end
    clr = 1'b0;

    foreach (vecs[i]) xact(vecs[i].inst, vecs[i].is_wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0);

    // Inputs changed after acceptance must not affect the request.
    xact(0, 1'b1, 9'h006, 32'h3333_3333, 32'h0, 1'b0);
    xact(0, 1'b1, 9'h005, 32'h1111_1111, 32'h0, 1'b1);
    xact(0, 1'b0, 9'h005, 32'h0, 32'h1111_1111, 1'b0);
    xact(0, 1'b0, 9'h006, 32'h0, 32'h3333_3333, 1'b0);

    // Both strobes together: error pulse, nothing accepted, RAM untouched.
    @(negedge clk);
    rd[0] = 1; wr[0] = 1; addr[0] = 9'h010; wdata[0] = 32'h0;
    @(negedge clk);
    rd[0] = 0; wr[0] = 0;
    chk("both_err", {31'b0, err[0]}, 32'd1);
    chk("both_busy", {31'b0, busy[0]}, 32'd0);
    @(negedge clk);
    chk("both_err_clear", {31'b0, err[0]}, 32'd0);
    chk("both_busy_after", {31'b0, busy[0]}, 32'd0);
    xact(0, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Held read strobe: back-to-back requests, done pulses LAT+2 apart.
    @(negedge clk);
    rd[0] = 1; addr[0] = 9'h010;
    for (int n = 1; n <= 2 * (LATS[0] + 2); n++) begin
      @(negedge clk);
      if (done[0]) begin
        dpos.push_back(n);
        chk("held_mdat", mdat[0], 32'hDEAD_BEEF);
      end
      if (n == 2 * (LATS[0] + 2)) rd[0] = 0;
    end
    chk("held_count", dpos.size(), 32'd2);
    if (dpos.size() == 2) begin
      chk("held_first", dpos[0], LATS[0] + 1);
      chk("held_gap", dpos[1] - dpos[0], LATS[0] + 2);
    end
    addr[0] = '0;
    @(negedge clk);
    chk("held_idle", {31'b0, busy[0]}, 32'd0);

    // Reset in the middle of a write (LAT=3): write is not committed.
    xact(3, 1'b1, 9'h0AA, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    wr[3] = 1; addr[3] = 9'h0AA; wdata[3] = 32'hCAFE_F00D;
    @(negedge clk);
    wr[3] = 0;
    chk("mid_busy_before_clr", {31'b0, busy[3]}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", {31'b0, busy[3]}, 32'd0);
    chk("clr_done", {31'b0, done[3]}, 32'd0);
    chk("clr_err", {31'b0, err[3]}, 32'd0);
    chk("clr_mdat", mdat[3], 32'd0);
    chk("clr_mdat_i0", mdat[0], 32'd0);
    for (int k = 0; k < NI; k++) last_rd[k] = '0;
    addr[3] = '0; wdata[3] = '0;
    xact(3, 1'b0, 9'h0AA, 32'h0, 32'h1234_5678, 1'b0);

    // Randomized traffic against the reference memory model.
    for (int i = 0; i < 60; i++) begin
      int          k;
      logic [8:0]  a;
      logic [31:0] d;
      bit          oor;
      bit          want_wr;
      k = $urandom_range(0, NI - 1);
      a = 9'(32'h40 + $urandom_range(0, 7));
      if (k == 3 && $urandom_range(0, 3) == 0) a = 9'(32'h100 + $urandom_range(0, 255));
      oor = (int'(a) >= DEPTHS[k]);
      d = $urandom;
      want_wr = $urandom_range(0, 1) == 1;
      if (!oor && !model.exists(key(k, a))) want_wr = 1'b1;
      if (want_wr) xact(k, 1'b1, a, d, 32'h0, 1'b0);
      else xact(k, 1'b0, a, 32'h0, oor ? 32'h0 : model[key(k, a)], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
